axi_mem_arbiter: RTL and testbench

AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

---
 rtl/axi_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_axi_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
`timescale 1ns/1ps
// axi_mem_arbiter: two-requester (instruction fetch / data) arbiter in front of
// a single-outstanding downstream memory bridge, with a per-transaction timeout.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// otherwise requester 0 has fixed priority.
module axi_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            req_valid,
  input  logic [2*AW-1:0]       req_addr,
  input  logic [2*DW-1:0]       req_wdata,
  input  logic [2*(DW/8)-1:0]   req_wstrb,
  output logic [1:0]            req_ready,
  output logic [DW-1:0]         req_rdata,
  output logic                  req_err,
  output logic                  mem_valid,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  output logic [DW/8-1:0]       mem_wstrb,
  input  logic                  mem_ready,
  input  logic [DW-1:0]         mem_rdata,
  output logic [1:0]            grant
);

  localparam int SW = DW / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Last counter value before the timeout fires; mem_valid is then high for
  // exactly TIMEOUT cycles.
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [9:0]    to_cnt;
  logic          win;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [SW-1:0] sel_wstrb;

`ifdef ARB_ROUND_ROBIN_EN
  logic last;

  // On a tie the requester not granted last time wins.
  always_comb begin
    win = (req_valid == 2'b11) ? ~last : req_valid[1];
  end

  // Remember the winner each time a transaction is launched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last <= 1'b0;
    end else if (state == S_IDLE && |req_valid) begin
      last <= win;
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it is requesting.
  always_comb begin
    win = ~req_valid[0];
  end
`endif

  // Steer the winning requester's fields toward the mem_* registers.
  always_comb begin
    sel_addr  = win ? req_addr[AW +: AW]   : req_addr[0 +: AW];
    sel_wdata = win ? req_wdata[DW +: DW]  : req_wdata[0 +: DW];
    sel_wstrb = win ? req_wstrb[SW +: SW]  : req_wstrb[0 +: SW];
  end

  // Transaction FSM: IDLE arbitrates, REQ waits on the bridge or timeout,
  // RESP spends one cycle preparing and one cycle presenting the ready pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      to_cnt    <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      grant     <= '0;
      req_ready <= '0;
      req_rdata <= '0;
      req_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            state     <= S_REQ;
            mem_valid <= 1'b1;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_wstrb <= sel_wstrb;
            grant     <= win ? 2'b10 : 2'b01;
            to_cnt    <= '0;
          end
        end
        S_REQ: begin
          to_cnt <= to_cnt + 10'd1;
          if (mem_ready) begin
            req_rdata <= mem_rdata;
            req_err   <= 1'b0;
            mem_valid <= 1'b0;
            state     <= S_RESP;
          end else if (to_cnt == TO_LAST) begin
            req_rdata <= '0;
            req_err   <= 1'b1;
            mem_valid <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          // First RESP cycle raises the pulse, second drops it and releases
          // the grant, so the requester's still-high valid is never re-arbitrated.
          if (req_ready == 2'b00) begin
            req_ready <= grant;
          end else begin
            req_ready <= '0;
            grant     <= '0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
`timescale 1ns/1ps
// Testbench for axi_mem_arbiter: randomized requests scored against a
// transaction-level model, with directed read/write/tie/timeout/reset cases.
module tb_axi_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic [1:0]        req_valid;
  logic [2*AW-1:0]   req_addr;
  logic [2*DW-1:0]   req_wdata;
  logic [2*SW-1:0]   req_wstrb;
  logic [1:0]        req_ready;
  logic [DW-1:0]     req_rdata;
  logic              req_err;
  logic              mem_valid;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [SW-1:0]     mem_wstrb;
  logic              mem_ready;
  logic [DW-1:0]     mem_rdata;
  logic [1:0]        grant;

  axi_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_ready(req_ready), .req_rdata(req_rdata),
    .req_err(req_err), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    grant;
    int            cyc;
  } mem_exp_t;

  typedef struct {
    logic [1:0]    ready;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_exp_t;

  mem_exp_t mq[$];
  rsp_exp_t rq[$];

  // Reference model state: outstanding request per requester, last winner.
  bit            pend [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  logic [SW-1:0] p_wstrb [2];
  bit            model_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic issue(input int r, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [SW-1:0] ws);
    pend[r]    = 1'b1;
    p_addr[r]  = a;
    p_wdata[r] = wd;
    p_wstrb[r] = ws;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = wd;
    req_wstrb[r*SW +: SW] = ws;
    req_valid[r] = 1'b1;
  endtask

  task automatic issue_rand(input int r);
    logic [SW-1:0] ws;
    ws = ($urandom_range(0, 2) == 0) ? '0 : SW'($urandom);
    issue(r, $urandom, $urandom, ws);
  endtask

  // Serve one transaction: the model picks the winner, the bridge answers on
  // mem_valid cycle d (d > TO means never, i.e. timeout).
  task automatic serve(input int d, input logic [DW-1:0] rd);
    int w;
    int k;
    bit err;
    mem_exp_t me;
    rsp_exp_t re;
    if (pend[0] && pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
      w = model_last ? 0 : 1;
`else
      w = 0;
`endif
    end else begin
      w = pend[1] ? 1 : 0;
    end
    model_last = (w == 1);
    err = (d > TO);
    me.addr  = p_addr[w];
    me.wdata = p_wdata[w];
    me.wstrb = p_wstrb[w];
    me.grant = (w == 1) ? 2'b10 : 2'b01;
    me.cyc   = err ? TO : d;
    re.ready = me.grant;
    re.rdata = err ? '0 : rd;
    re.err   = err;
    mq.push_back(me);
    rq.push_back(re);

    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mem_valid && k < 10);
    if (!mem_valid) begin
      tests++; fails++;
      $display("FAIL mem_valid_wait: actual 0, expected 1 within 10 cycles");
      finish_run();
    end

    k = 1;
    while (mem_valid && k <= 2*TO + 4) begin
      mem_ready = (k == d);
      mem_rdata = (k == d) ? rd : DW'($urandom);
      // Idle requester lines wiggle mid-transaction; must not disturb mem_*/grant.
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          req_valid[r] = 1'($urandom);
          req_addr[r*AW +: AW] = $urandom;
        end
      end
      @(negedge clk);
      k++;
    end
    mem_ready = 1'b0;
    for (int r = 0; r < 2; r++) if (!pend[r]) req_valid[r] = 1'b0;
    if (mem_valid) begin
      tests++; fails++;
      $display("FAIL mem_valid_stuck: actual 1, expected 0 after %0d cycles", k);
      finish_run();
    end

    k = 0;
    while (req_ready == 2'b00 && k < 6) begin
      @(negedge clk);
      k++;
    end
    if (req_ready == 2'b00) begin
      tests++; fails++;
      $display("FAIL req_ready_wait: actual 0, expected %0b", me.grant);
      finish_run();
    end
    pend[w] = 1'b0;
    req_valid[w] = 1'b0;
    @(negedge clk);
    chk("req_ready_one_cycle", req_ready, 2'b00);
    chk("grant_released", grant, 2'b00);
  endtask

  // Monitor: checks mem-side requests and requester responses against queues.
  initial begin : monitor
    mem_exp_t cur;
    rsp_exp_t rexp;
    bit in_txn;
    int cyc;
    in_txn = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mq.delete();
        rq.delete();
        in_txn = 1'b0;
        cyc = 0;
      end else begin
        if (mem_valid) begin
          if (!in_txn) begin
            if (mq.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_mem_valid: actual 1, expected 0");
              cur = '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb, grant: grant, cyc: 0};
            end else begin
              cur = mq.pop_front();
            end
            in_txn = 1'b1;
            cyc = 0;
          end
          cyc++;
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_wdata", mem_wdata, cur.wdata);
          chk("mem_wstrb", mem_wstrb, cur.wstrb);
          chk("grant", grant, cur.grant);
        end else if (in_txn) begin
          chk("mem_valid_cycles", cyc, cur.cyc);
          in_txn = 1'b0;
        end
        if (req_ready != 2'b00) begin
          if (rq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_req_ready: actual %0b, expected 00", req_ready);
          end else begin
            rexp = rq.pop_front();
            chk("req_ready", req_ready, rexp.ready);
            chk("req_rdata", req_rdata, rexp.rdata);
            chk("req_err", req_err, rexp.err);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin : stimulus
    mem_exp_t me;
    resetn    = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_req_err", req_err, 0);
    chk("rst_req_rdata", req_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);

    // Single read, bridge answers on the third mem_valid cycle.
    issue(0, 32'h0000_0100, 32'h0, 4'h0);
    serve(3, 32'hDEAD_BEEF);

    // Data-side write.
    issue(1, 32'h0000_2000, 32'h1234_5678, 4'hF);
    serve(2, 32'h0);

    // Answer on the very last cycle before timeout still succeeds.
    issue(0, 32'h0000_0300, 32'h0, 4'h0);
    serve(TO, 32'hCAFE_F00D);

    // Spurious mem_ready while idle is ignored.
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("spurious_mem_valid", mem_valid, 0);
    chk("spurious_req_ready", req_ready, 0);
    chk("spurious_grant", grant, 0);
    repeat (3) @(negedge clk);
    chk("spurious_req_ready_later", req_ready, 0);
    chk("spurious_mem_valid_later", mem_valid, 0);

    // Reset in the middle of a transaction aborts it without completion.
    issue(0, 32'h0000_0400, 32'h0, 4'h0);
    me = '{addr: 32'h0000_0400, wdata: 32'h0, wstrb: 4'h0, grant: 2'b01, cyc: 0};
    mq.push_back(me);
    begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!mem_valid && k < 10);
    end
    chk("pre_reset_mem_valid", mem_valid, 1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_mem_valid", mem_valid, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_req_ready", req_ready, 0);
    req_valid  = '0;
    pend[0]    = 1'b0;
    pend[1]    = 1'b0;
    model_last = 1'b0;
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    issue(1, 32'h0000_0500, 32'hA5A5_5A5A, 4'h3);
    serve(1, 32'h0);

    // Reset again so the tie sequence starts from a cleared pointer.
    @(negedge clk);
    #2 resetn = 1'b0;
    model_last = 1'b0;
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);

    // Both requesters held for four transactions.
    issue(0, 32'h0000_1000, 32'h0, 4'h0);
    issue(1, 32'h0000_1004, 32'h1111_2222, 4'hC);
    for (int i = 0; i < 4; i++) begin
      serve(2, $urandom);
      for (int r = 0; r < 2; r++) if (!pend[r]) issue_rand(r);
    end

    // Timeout on whichever request is pending; bridge never answers.
    serve(TO + 12, $urandom);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) issue_rand(r);
      end
      if (!pend[0] && !pend[1]) issue_rand($urandom_range(0, 1));
      serve($urandom_range(1, TO + 3), $urandom);
    end

    // Drain whatever is still pending.
    while (pend[0] || pend[1]) serve($urandom_range(1, TO), $urandom);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(mq.size() + rq.size()), 0);
    finish_run();
  end

endmodule
